// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit registers with byte strobes.
// Independent write and read FSMs; out-of-range accesses answer SLVERR.
module axi_lite_slave_regs #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 32
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [ADDR_W-1:0]        awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   regs_flat
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state_reg, w_state_next;
  r_state_t r_state_reg, r_state_next;

  logic              ready_en_reg;
  logic [ADDR_W-1:0] awaddr_reg;
  logic [31:0]       wdata_reg;
  logic [3:0]        wstrb_reg;
  logic [31:0]       regs_reg [NUM_REGS];
  logic [31:0]       rdata_reg;
  logic [1:0]        rresp_reg;
  logic [1:0]        bresp_reg;

  logic              aw_take, w_take, ar_take, commit;
  logic [ADDR_W-1:0] wr_addr, wr_word, rd_word;
  logic [31:0]       wr_data;
  logic [3:0]        wr_strb;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              wr_in_range, rd_in_range;

  // Readies stay low through reset and rise on the first edge after release.
  always_comb begin
    w_state_next = w_state_reg;
    awready      = 1'b0;
    wready       = 1'b0;
    bvalid       = 1'b0;
    aw_take      = 1'b0;
    w_take       = 1'b0;
    commit       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        awready = ready_en_reg;
        wready  = ready_en_reg;
        if (ready_en_reg) begin
          aw_take = awvalid;
          w_take  = wvalid;
          if (awvalid && wvalid) begin
            w_state_next = W_RESP;
            commit       = 1'b1;
          end else if (awvalid) begin
            w_state_next = W_HAVE_A;
          end else if (wvalid) begin
            w_state_next = W_HAVE_D;
          end
        end
      end
      W_HAVE_A: begin
        wready = 1'b1;
        if (wvalid) begin
          w_take       = 1'b1;
          w_state_next = W_RESP;
          commit       = 1'b1;
        end
      end
      W_HAVE_D: begin
        awready = 1'b1;
        if (awvalid) begin
          aw_take      = 1'b1;
          w_state_next = W_RESP;
          commit       = 1'b1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_next = r_state_reg;
    arready      = 1'b0;
    rvalid       = 1'b0;
    ar_take      = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        arready = ready_en_reg;
        if (ready_en_reg && arvalid) begin
          ar_take      = 1'b1;
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  // Whichever half arrived first was latched; the other comes straight from the bus.
  assign wr_addr     = (w_state_reg == W_HAVE_A) ? awaddr_reg : awaddr;
  assign wr_data     = (w_state_reg == W_HAVE_D) ? wdata_reg  : wdata;
  assign wr_strb     = (w_state_reg == W_HAVE_D) ? wstrb_reg  : wstrb;
  assign wr_word     = wr_addr >> 2;
  assign wr_idx      = wr_word[IDX_W-1:0];
  assign wr_in_range = (wr_word < ADDR_W'(NUM_REGS));
  assign rd_word     = araddr >> 2;
  assign rd_idx      = rd_word[IDX_W-1:0];
  assign rd_in_range = (rd_word < ADDR_W'(NUM_REGS));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_reg  <= W_IDLE;
      r_state_reg  <= R_IDLE;
      ready_en_reg <= 1'b0;
      awaddr_reg   <= '0;
      wdata_reg    <= '0;
      wstrb_reg    <= '0;
      rdata_reg    <= '0;
      rresp_reg    <= RESP_OKAY;
      bresp_reg    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      w_state_reg  <= w_state_next;
      r_state_reg  <= r_state_next;
      ready_en_reg <= 1'b1;
      if (aw_take) awaddr_reg <= awaddr;
      if (w_take) begin
        wdata_reg <= wdata;
        wstrb_reg <= wstrb;
      end
      if (commit) begin
        bresp_reg <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        if (wr_in_range) begin
          for (int k = 0; k < 4; k++) begin
            if (wr_strb[k]) regs_reg[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
      // Non-blocking read of regs_reg yields the pre-write value on a same-edge commit.
      if (ar_take) begin
        rdata_reg <= rd_in_range ? regs_reg[rd_idx] : 32'h0;
        rresp_reg <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign bresp = bresp_reg;
  assign rdata = rdata_reg;
  assign rresp = rresp_reg;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[32*gi +: 32] = regs_reg[gi];
    end
  endgenerate

endmodule
